boreal_cursor_integrator: RTL and testbench



---
 rtl/boreal_cursor_pkg.sv | 29 ++
 rtl/boreal_axis_integrator.sv | 101 ++++++++++
 rtl/boreal_cursor_integrator.sv | 132 +++++++++++++
 tb/tb_boreal_cursor_integrator.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/boreal_cursor_pkg.sv
// Shared types and constants for the boreal cursor integrator.
// Holds the report FSM encoding, HID delta limit and the accumulator saturation helper.
package boreal_cursor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int HID_DELTA_MAX = 127;
  localparam int ACC_W         = 32;

  localparam logic signed [ACC_W:0] SAT_HI = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_LO = -SAT_HI;

  // Clamp a one-bit-wider sum back into the symmetric accumulator range.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
    logic signed [ACC_W:0] t;
    if (s > SAT_HI) begin
      t = SAT_HI;
    end else if (s < SAT_LO) begin
      t = SAT_LO;
    end else begin
      t = s;
    end
    return t[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/boreal_axis_integrator.sv
// One cursor axis: sub-pixel accumulator, delta extraction with HID and screen-edge limits, position.
// BOREAL_CURSOR_DEADBAND_EN adds an input magnitude deadband ahead of the accumulator.
module boreal_axis_integrator
  import boreal_cursor_pkg::*;
#(
  parameter int FRAC_BITS = 12,
  parameter int BOUND     = 1920
`ifdef BOREAL_CURSOR_DEADBAND_EN
  , parameter logic [23:0] DEADBAND = 24'h000080
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [23:0] v_in,
  input  logic        extract,
  output logic [7:0]  delta,
  output logic [11:0] pos
);

  localparam logic signed [ACC_W-1:0] DMAX     = ACC_W'(HID_DELTA_MAX);
  localparam logic signed [ACC_W-1:0] BOUND_M1 = ACC_W'(BOUND - 1);

  logic signed [ACC_W-1:0] acc_r, acc_nx_s, v_s, nacc_s, q_s, dc_s, d_s, lo_s, hi_s, pos_ext_s;
  logic                    limited_s;
  logic [11:0]             pos_r;
`ifdef BOREAL_CURSOR_DEADBAND_EN
  logic [23:0]             mag_s;
`endif

  // Qualified, sign-extended velocity sample (deadband applied when enabled).
  always_comb begin
    v_s = '0;
`ifdef BOREAL_CURSOR_DEADBAND_EN
    mag_s = v_in[23] ? (24'd0 - v_in) : v_in;
    if (valid && (mag_s >= DEADBAND)) begin
      v_s = {{(ACC_W-24){v_in[23]}}, v_in};
    end else begin
      v_s = '0;
    end
`else
    if (valid) begin
      v_s = {{(ACC_W-24){v_in[23]}}, v_in};
    end else begin
      v_s = '0;
    end
`endif
  end

  // Delta extraction: floor, HID clamp, then screen-edge limit with anti-windup flag.
  always_comb begin
    nacc_s    = sat_acc({acc_r[ACC_W-1], acc_r} + {v_s[ACC_W-1], v_s});
    q_s       = nacc_s >>> FRAC_BITS;
    pos_ext_s = {{(ACC_W-12){1'b0}}, pos_r};
    lo_s      = -pos_ext_s;
    hi_s      = BOUND_M1 - pos_ext_s;
    limited_s = 1'b0;
    if (q_s > DMAX) begin
      dc_s = DMAX;
    end else if (q_s < -DMAX) begin
      dc_s = -DMAX;
    end else begin
      dc_s = q_s;
    end
    if (dc_s < lo_s) begin
      d_s       = lo_s;
      limited_s = 1'b1;
    end else if (dc_s > hi_s) begin
      d_s       = hi_s;
      limited_s = 1'b1;
    end else begin
      d_s       = dc_s;
    end
    if (!extract) begin
      acc_nx_s = nacc_s;
    end else if (limited_s) begin
      acc_nx_s = '0;
    end else begin
      acc_nx_s = nacc_s - (d_s <<< FRAC_BITS);
    end
  end

  // Accumulator and position registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= '0;
      pos_r <= 12'(BOUND / 2);
    end else begin
      acc_r <= acc_nx_s;
      if (extract) begin
        pos_r <= pos_r + d_s[11:0];
      end else begin
        pos_r <= pos_r;
      end
    end
  end

  assign delta = d_s[7:0];
  assign pos   = pos_r;

endmodule

// File: rtl/boreal_cursor_integrator.sv
// Cursor integrator top: report tick divider, IDLE/WAIT report FSM, valid/ready handshake, overrun count.
// BOREAL_CURSOR_DEADBAND_EN enables the per-axis input deadband (DEADBAND parameter).
module boreal_cursor_integrator
  import boreal_cursor_pkg::*;
#(
  parameter int FRAC_BITS  = 12,
  parameter int REPORT_DIV = 100000,
  parameter int SCREEN_W   = 1920,
  parameter int SCREEN_H   = 1080
`ifdef BOREAL_CURSOR_DEADBAND_EN
  , parameter logic [23:0] DEADBAND = 24'h000080
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [23:0] vx_in,
  input  logic [23:0] vy_in,
  output logic        rpt_valid,
  input  logic        rpt_ready,
  output logic [7:0]  rpt_dx,
  output logic [7:0]  rpt_dy,
  output logic [11:0] pos_x,
  output logic [11:0] pos_y,
  output logic [7:0]  overrun_cnt
);

  localparam int                CNT_W   = (REPORT_DIV > 1) ? $clog2(REPORT_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REPORT_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_s, extract_s, hs_s;
  logic [7:0]       dx_s, dy_s;
  state_t           state_r, state_nx_s;

  assign tick_s    = (cnt_r == CNT_MAX);
  assign extract_s = (state_r == IDLE) && tick_s;
  assign hs_s      = rpt_valid && rpt_ready;

  boreal_axis_integrator #(
    .FRAC_BITS(FRAC_BITS),
    .BOUND    (SCREEN_W)
`ifdef BOREAL_CURSOR_DEADBAND_EN
    , .DEADBAND(DEADBAND)
`endif
  ) u_axis_x (
    .clk(clk), .rst_n(rst_n), .valid(valid), .v_in(vx_in),
    .extract(extract_s), .delta(dx_s), .pos(pos_x)
  );

  boreal_axis_integrator #(
    .FRAC_BITS(FRAC_BITS),
    .BOUND    (SCREEN_H)
`ifdef BOREAL_CURSOR_DEADBAND_EN
    , .DEADBAND(DEADBAND)
`endif
  ) u_axis_y (
    .clk(clk), .rst_n(rst_n), .valid(valid), .v_in(vy_in),
    .extract(extract_s), .delta(dy_s), .pos(pos_y)
  );

  // Report tick divider.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (tick_s) begin
          state_nx_s = WAIT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT: begin
        if (hs_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Report registers, held until the packer accepts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_valid <= 1'b0;
      rpt_dx    <= 8'd0;
      rpt_dy    <= 8'd0;
    end else if (extract_s) begin
      rpt_valid <= 1'b1;
      rpt_dx    <= dx_s;
      rpt_dy    <= dy_s;
    end else if ((state_r == WAIT) && hs_s) begin
      rpt_valid <= 1'b0;
    end else begin
      rpt_valid <= rpt_valid;
    end
  end

  // Saturating count of ticks that land while a report is still pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_cnt <= 8'd0;
    end else if ((state_r == WAIT) && tick_s && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end else begin
      overrun_cnt <= overrun_cnt;
    end
  end

endmodule

// File: tb/tb_boreal_cursor_integrator.sv
// Directed self-checking bench for boreal_cursor_integrator (REPORT_DIV=8, 1920x1080, FRAC_BITS=12).
// Expectations are hand-computed; report ticks fall on cycles 7, 15, 23, ... after reset release.
module tb_boreal_cursor_integrator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        rpt_ready = 1'b0;
  logic [23:0] vx_in = 24'd0;
  logic [23:0] vy_in = 24'd0;
  logic        rpt_valid;
  logic [7:0]  rpt_dx, rpt_dy, overrun_cnt;
  logic [11:0] pos_x, pos_y;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef BOREAL_CURSOR_DEADBAND_EN
  localparam logic [7:0]  DY_DB1 = 8'h00;
  localparam logic [7:0]  DY_DB2 = 8'hFF;
  localparam logic [11:0] PY_DB1 = 12'd532;
`else
  localparam logic [7:0]  DY_DB1 = 8'hFF;
  localparam logic [7:0]  DY_DB2 = 8'h00;
  localparam logic [11:0] PY_DB1 = 12'd531;
`endif

  always #5 clk = ~clk;

  boreal_cursor_integrator #(
    .FRAC_BITS(12), .REPORT_DIV(8), .SCREEN_W(1920), .SCREEN_H(1080)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .vx_in(vx_in), .vy_in(vy_in),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_dx(rpt_dx), .rpt_dy(rpt_dy),
    .pos_x(pos_x), .pos_y(pos_y), .overrun_cnt(overrun_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle, then land on the next negedge for sampling.
  task automatic cyc(input logic v, input logic [23:0] vx, input logic [23:0] vy, input logic rdy);
    valid = v; vx_in = vx; vy_in = vy; rpt_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) cyc(1'b0, 24'd0, 24'd0, rdy);
  endtask

  initial begin
    idle(3, 1'b0);
    rst_n = 1'b1;
    // cycle 0: reset state
    check("rst_valid0", {31'd0, rpt_valid}, 32'd0);
    check("rst_pos_x", pos_x, 960);
    check("rst_pos_y", pos_y, 540);
    check("rst_dx", rpt_dx, 0);
    check("rst_ovr", overrun_cnt, 0);
    idle(8, 1'b0);
    check("keepalive_valid", rpt_valid, 1);
    check("keepalive_dx", rpt_dx, 0);
    check("keepalive_dy", rpt_dy, 0);

    // 8 valids of +1 px x / -1 px y, handshake of the keep-alive on the first
    cyc(1'b1, 24'h001000, 24'hFFF000, 1'b1);
    check("hs_drop", rpt_valid, 0);
    repeat (7) cyc(1'b1, 24'h001000, 24'hFFF000, 1'b1);
    check("int_valid", rpt_valid, 1);
    check("int_dx", rpt_dx, 8'h08);
    check("int_dy", rpt_dy, 8'hF8);
    check("int_pos_x", pos_x, 968);
    check("int_pos_y", pos_y, 532);

    // 3 x 0.5 px -> 1 px with 0.5 px residual
    idle(4, 1'b1);
    repeat (3) cyc(1'b1, 24'h000800, 24'd0, 1'b1);
    idle(1, 1'b1);
    check("frac_dx", rpt_dx, 8'h01);
    check("frac_pos_x", pos_x, 969);
    idle(8, 1'b1);
    check("resid_dx", rpt_dx, 8'h00);
    check("resid_pos_x", pos_x, 969);

    // cancel residual, then -256 px split across HID-limited reports
    cyc(1'b1, 24'hFFF800, 24'd0, 1'b1);
    cyc(1'b1, 24'hF00000, 24'd0, 1'b1);
    idle(6, 1'b1);
    check("neg1_dx", rpt_dx, 8'h81);
    check("neg1_pos_x", pos_x, 842);
    idle(8, 1'b1);
    check("neg2_dx", rpt_dx, 8'h81);
    check("neg2_pos_x", pos_x, 715);
    idle(8, 1'b1);
    check("neg3_dx", rpt_dx, 8'hFE);
    check("neg3_pos_x", pos_x, 713);

    // backpressure across 3 ticks; input keeps accumulating meanwhile
    idle(4, 1'b0);
    cyc(1'b1, 24'h003000, 24'd0, 1'b0);
    idle(19, 1'b0);
    check("hold_valid", rpt_valid, 1);
    check("hold_dx", rpt_dx, 8'hFE);
    check("ovr3", overrun_cnt, 3);
    idle(1, 1'b1);
    check("bp_hs_drop", rpt_valid, 0);
    idle(7, 1'b1);
    check("bp_dx", rpt_dx, 8'h03);
    check("bp_pos_x", pos_x, 716);
    // handshake on a tick cycle: counted as overrun, no report issued
    idle(7, 1'b0);
    idle(1, 1'b1);
    check("hs_tick_valid", rpt_valid, 0);
    check("ovr4", overrun_cnt, 4);
    idle(8, 1'b1);
    check("after_ovr_valid", rpt_valid, 1);
    check("after_ovr_dx", rpt_dx, 8'h00);

    // drive toward the right edge: 1202 px -> 9 x 127 + 59
    cyc(1'b1, 24'h4B2000, 24'd0, 1'b1);
    idle(7, 1'b1);
    check("run_dx_0", rpt_dx, 8'h7F);
    for (int k = 1; k < 9; k++) begin
      idle(8, 1'b1);
      check("run_dx", rpt_dx, 8'h7F);
      check("run_pos_x", pos_x, 32'(716 + 127 * (k + 1)));
    end
    idle(8, 1'b1);
    check("edge_pre_dx", rpt_dx, 8'h3B);
    check("edge_pre_pos_x", pos_x, 1918);
    // +10 px at 1918 -> limited to +1, accumulator cleared
    cyc(1'b1, 24'h00A000, 24'd0, 1'b1);
    idle(7, 1'b1);
    check("edge_dx", rpt_dx, 8'h01);
    check("edge_pos_x", pos_x, 1919);
    // -0.5 px after anti-windup floors to -1
    cyc(1'b1, 24'hFFF800, 24'd0, 1'b1);
    idle(7, 1'b1);
    check("windup_dx", rpt_dx, 8'hFF);
    check("windup_pos_x", pos_x, 1918);

    // deadband boundary on y: |v| = 0x7F then 0x80
    repeat (8) cyc(1'b1, 24'd0, 24'hFFFF81, 1'b1);
    check("db7f_dy", rpt_dy, DY_DB1);
    check("db7f_pos_y", pos_y, PY_DB1);
    check("db7f_dx", rpt_dx, 8'h00);
    repeat (8) cyc(1'b1, 24'd0, 24'hFFFF80, 1'b1);
    check("db80_dy", rpt_dy, DY_DB2);
    check("db80_pos_y", pos_y, 531);

    // reset while a report is pending
    idle(2, 1'b0);
    rst_n = 1'b0;
    idle(1, 1'b0);
    rst_n = 1'b1;
    check("mid_rst_valid", rpt_valid, 0);
    check("mid_rst_pos_x", pos_x, 960);
    check("mid_rst_pos_y", pos_y, 540);
    check("mid_rst_ovr", overrun_cnt, 0);
    idle(8, 1'b0);
    check("mid_rst_rpt_valid", rpt_valid, 1);
    check("mid_rst_rpt_dx", rpt_dx, 8'h00);
    check("mid_rst_rpt_dy", rpt_dy, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
